bus_demux_bridge: RTL
=====================

// Module: bus_demux_bridge
// PURPOSE
//  Master-to-peripheral bridge: one CPU data-bus master fans out to 4 peripheral slots.
//  Address decode steers each request to exactly one slot (demux direction). The read data
//  of the selected slot returns to the master through a registered read path.
//  Sits between the CPU memory stage and the timer/UART/LED/switch peripherals.
//  Per-transfer FSM with ack handshake and bounded wait.
// PARAMETERS
//  BASE0..BASE3  32'h7F00,32'h7F10,32'h7F20,32'h7F30  slot base address
//  MASK0..MASK3  32'hFFFF_FFF0 (all)                  slot hits when (m_addr & MASKi) == BASEi
//  TIMEOUT       16                                   max BUSY cycles without ack (1..255)
// PORTS
//  clk       in   1    rising-edge clock
//  reset_n   in   1    synchronous, active-low reset
//  m_req     in   1    master request, sampled only in IDLE
//  m_we      in   1    1=write, 0=read
//  m_addr    in   32   byte address
//  m_wdata   in   32   write data
//  m_byteen  in   4    write byte enables
//  m_ready   out  1    1-cycle pulse: transfer complete
//  m_err     out  1    valid with m_ready: decode miss or timeout
//  m_rdata   out  32   read data, valid with m_ready
//  s_sel     out  4    one-hot slot select, held through BUSY
//  s_we      out  1    latched m_we, gated by s_sel != 0
//  s_addr    out  32   latched address
//  s_wdata   out  32   latched write data
//  s_byteen  out  4    latched byte enables
//  s_rdata   in   128  slot i read data on [32*i+31:32*i]
//  s_ack     in   4    slot i done; only ack of the selected slot counts
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): state=IDLE; every output, latch and counter cleared to 0.
//  States: IDLE, BUSY, DONE.
//  IDLE: m_req=1 latches addr/wdata/byteen/we and decodes.
//   - Hit: go BUSY with slot = lowest matching index (overlap: lower index wins).
//   - Miss: go DONE with err=1, rdata=0.
//  BUSY: s_sel=1<<slot; s_we/s_addr/s_wdata/s_byteen stable for the whole state.
//   - s_ack[slot]=1: capture s_rdata slice (0 on write), err=0, go DONE.
//   - Acks on other slots are ignored.
//  DONE: exactly one cycle with m_ready=1, m_err and m_rdata valid; s_sel=0, s_we=0; go IDLE.
//   - m_rdata/m_err are 0 outside DONE.
//  Latency: req sampled at cycle 0, BUSY at cycle 1.
//   - Ack at cycle 1 gives m_ready at cycle 2; each cycle of ack delay adds one cycle.
//   - Decode miss: m_ready at cycle 1.
//  No back-to-back: m_req is ignored in BUSY/DONE. Master holds or reissues after m_ready.
//   - A req present in the cycle after DONE starts a new transfer.
//  Reset mid-BUSY: transfer aborted, no m_ready, s_sel drops to 0 next edge.
//  Write strobe: the slave must treat s_sel&s_we as an active write every BUSY cycle until ack.
// CONFIGURATION
//  BRIDGE_TIMEOUT_EN defined:
//   - 8-bit wait counter: cleared on IDLE->BUSY, +1 per BUSY cycle without ack.
//   - Counter reaching TIMEOUT goes DONE with err=1, rdata=0.
//   - Ack in the same cycle as expiry wins: err=0, data captured.
//  Not defined: no counter; BUSY waits indefinitely for ack.
// TESTING
//  1 Read, zero-wait: req, we=0, addr=7F14; slot1 acks same cycle, rdata=DEADBEEF
//    -> s_sel=0010 in cycle 1; m_ready, rdata=DEADBEEF, err=0 in cycle 2.
//  2 Write, 3-cycle ack: addr=7F38, wdata=12345678, byteen=0011
//    -> s_sel=1000 for 3 cycles with fields stable; m_ready 1 cycle after ack; m_rdata=0.
//  3 Miss: addr=00001000 -> s_sel never set; cycle 1: m_ready=1, err=1, rdata=0.
//  4 Stray ack: slot2 selected, s_ack=0001 -> no completion; later s_ack=0100 completes.
//  5 Timeout (EN, TIMEOUT=16): slot0, no ack -> m_ready, err=1 after 16 BUSY cycles.
//    Ack on the 16th cycle -> err=0. Without EN: still BUSY at cycle 100.
//  6 Reset: reset_n=0 in BUSY -> next edge all outputs 0, IDLE. Next req completes normally.

Source files
------------

// File: rtl/bus_demux_bridge.sv
// Single-master to 4-slot peripheral bridge: address decode, held slot strobes, registered read return.
// Optional BRIDGE_TIMEOUT_EN adds a bounded BUSY wait that completes with err=1 on expiry.
module bdb_slot_dec #(
  parameter logic [31:0] BASE = 32'h0000_7F00,
  parameter logic [31:0] MASK = 32'hFFFF_FFF0
) (
  input  logic [31:0] i_addr,
  output logic        o_hit
);
  assign o_hit = ((i_addr & MASK) == BASE);
endmodule

module bus_demux_bridge #(
  parameter logic [31:0] BASE0   = 32'h0000_7F00,
  parameter logic [31:0] BASE1   = 32'h0000_7F10,
  parameter logic [31:0] BASE2   = 32'h0000_7F20,
  parameter logic [31:0] BASE3   = 32'h0000_7F30,
  parameter logic [31:0] MASK0   = 32'hFFFF_FFF0,
  parameter logic [31:0] MASK1   = 32'hFFFF_FFF0,
  parameter logic [31:0] MASK2   = 32'hFFFF_FFF0,
  parameter logic [31:0] MASK3   = 32'hFFFF_FFF0,
  parameter int          TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         m_req,
  input  logic         m_we,
  input  logic [31:0]  m_addr,
  input  logic [31:0]  m_wdata,
  input  logic [3:0]   m_byteen,
  output logic         m_ready,
  output logic         m_err,
  output logic [31:0]  m_rdata,
  output logic [3:0]   s_sel,
  output logic         s_we,
  output logic [31:0]  s_addr,
  output logic [31:0]  s_wdata,
  output logic [3:0]   s_byteen,
  input  logic [127:0] s_rdata,
  input  logic [3:0]   s_ack
);
  localparam int NUM_SLOTS = 4;
  localparam logic [NUM_SLOTS-1:0][31:0] SLOT_BASE = {BASE3, BASE2, BASE1, BASE0};
  localparam logic [NUM_SLOTS-1:0][31:0] SLOT_MASK = {MASK3, MASK2, MASK1, MASK0};

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t                        r_state, w_state_nxt;
  logic [1:0]                    r_slot;
  logic                          r_we;
  logic [31:0]                   r_addr, r_wdata, r_rdata;
  logic [3:0]                    r_byteen;
  logic                          r_err;

  logic [NUM_SLOTS-1:0]          w_hit;
  logic                          w_any_hit;
  logic [1:0]                    w_slot;
  logic [NUM_SLOTS-1:0][31:0]    w_rdata_v;
  logic                          w_ack_sel;
  logic                          w_expire;

  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_dec
      bdb_slot_dec #(.BASE(SLOT_BASE[g]), .MASK(SLOT_MASK[g])) u_dec (
        .i_addr (m_addr),
        .o_hit  (w_hit[g])
      );
    end
  endgenerate

  // Scan high to low so the lowest matching slot wins on overlapping windows.
  always_comb begin
    w_slot = 2'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_hit[i]) w_slot = 2'(i);
    end
  end

  assign w_any_hit = |w_hit;
  assign w_rdata_v = s_rdata;
  assign w_ack_sel = s_ack[r_slot];

`ifdef BRIDGE_TIMEOUT_EN
  logic [7:0] r_wcnt;
  assign w_expire = (r_wcnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wcnt <= 8'd0;
    end else if (r_state == ST_IDLE) begin
      r_wcnt <= 8'd0;
    end else if (r_state == ST_BUSY && !w_ack_sel) begin
      r_wcnt <= r_wcnt + 8'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^8'(TIMEOUT);
  assign w_expire         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (m_req) w_state_nxt = w_any_hit ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_ack_sel || w_expire) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_slot   <= 2'd0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_byteen <= 4'd0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m_req) begin
            r_slot   <= w_slot;
            r_we     <= m_we;
            r_addr   <= m_addr;
            r_wdata  <= m_wdata;
            r_byteen <= m_byteen;
            r_err    <= ~w_any_hit;
            r_rdata  <= 32'd0;
          end
        end
        ST_BUSY: begin
          // An ack landing on the expiry cycle still counts as a good completion.
          if (w_ack_sel) begin
            r_err   <= 1'b0;
            r_rdata <= r_we ? 32'd0 : w_rdata_v[r_slot];
          end else if (w_expire) begin
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
          end
        end
        ST_DONE: begin
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
        end
        default: ;
      endcase
    end
  end

  assign s_sel    = (r_state == ST_BUSY) ? (4'b0001 << r_slot) : 4'b0000;
  assign s_we     = r_we & (|s_sel);
  assign s_addr   = r_addr;
  assign s_wdata  = r_wdata;
  assign s_byteen = r_byteen;

  assign m_ready  = (r_state == ST_DONE);
  assign m_err    = m_ready & r_err;
  assign m_rdata  = m_ready ? r_rdata : 32'd0;
endmodule
